// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: latches one block operation,
// waits for the key schedule, then steps the shared round datapath once per cycle.
module aes_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dec_in,
  input  logic [1:0] mode_in,
  input  logic       key_ready,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       busy,
  output logic       state_ld,
  output logic       state_en,
  output logic [4:0] round,
  output logic [1:0] mode,
  output logic       dec,
  output logic       last_round,
  output logic       out_valid
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, RUN, DONE} state_t;

  state_t     state, state_nx;
  logic [4:0] round_nx;
  logic [1:0] mode_nx;
  logic       dec_nx;
  logic [4:0] first_cur, final_cur;

  function automatic logic [4:0] num_rounds(input logic [1:0] m);
    logic [4:0] nr;
    case (m)
      2'h2:    nr = 5'd12;
      2'h3:    nr = 5'd14;
      default: nr = 5'd10;
    endcase
    return nr;
  endfunction

  // Decrypt rounds are numbered Nr+1 .. 2*Nr+1 so the last one is the value
  // on which inv_mixColumns bypasses itself.
  function automatic logic [4:0] first_round(input logic d, input logic [1:0] m);
    return d ? num_rounds(m) + 5'd1 : 5'd0;
  endfunction

  function automatic logic [4:0] final_round(input logic d, input logic [1:0] m);
    return d ? (num_rounds(m) << 1) + 5'd1 : num_rounds(m);
  endfunction

  assign first_cur = first_round(dec, mode);
  assign final_cur = final_round(dec, mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round <= 5'h00;
      mode  <= 2'h0;
      dec   <= 1'b0;
    end else begin
      state <= state_nx;
      round <= round_nx;
      mode  <= mode_nx;
      dec   <= dec_nx;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    state_nx   = state;
    round_nx   = round;
    mode_nx    = mode;
    dec_nx     = dec;
    in_ready   = 1'b0;
    busy       = 1'b1;
    state_ld   = 1'b0;
    state_en   = 1'b0;
    last_round = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (start) begin
          dec_nx   = dec_in;
          mode_nx  = mode_in;
          round_nx = first_round(dec_in, mode_in);
          state_nx = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (key_ready) state_nx = RUN;
      end
      RUN: begin
        state_en = 1'b1;
        state_ld = (round == first_cur);
        if (round == final_cur) begin
          last_round = 1'b1;
          state_nx   = DONE;
        end else begin
          round_nx = round + 5'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a per-cycle reference model plus
// directed operations with hand-computed round ranges and latencies.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, dec_in, key_ready, out_ready;
  logic [1:0] mode_in;
  logic       in_ready, busy, state_ld, state_en, dec, last_round, out_valid;
  logic [4:0] round;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dec_in(dec_in), .mode_in(mode_in),
    .key_ready(key_ready), .out_ready(out_ready), .in_ready(in_ready), .busy(busy),
    .state_ld(state_ld), .state_en(state_en), .round(round), .mode(mode), .dec(dec),
    .last_round(last_round), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic [1:0] m,
                               input logic k, input logic o);
    start     = s;
    dec_in    = d;
    mode_in   = m;
    key_ready = k;
    out_ready = o;
    @(posedge clk);
    #2;
  endtask

  // Reference model: phase 0 idle, 1 waiting for key, 2 running, 3 result held.
  function automatic int nr_of(input logic [1:0] m);
    return (m == 2'h2) ? 12 : (m == 2'h3) ? 14 : 10;
  endfunction
  function automatic int first_of(input logic d, input logic [1:0] m);
    return d ? nr_of(m) + 1 : 0;
  endfunction
  function automatic int final_of(input logic d, input logic [1:0] m);
    return d ? 2 * nr_of(m) + 1 : nr_of(m);
  endfunction

  int         m_phase = 0;
  int         m_round = 0;
  logic [1:0] m_mode  = 2'h0;
  logic       m_dec   = 1'b0;
  bit         m_live  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_round <= 0;
      m_mode  <= 2'h0;
      m_dec   <= 1'b0;
      m_live  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_dec   <= dec_in;
             m_mode  <= mode_in;
             m_round <= first_of(dec_in, mode_in);
             m_phase <= 1;
           end
        1: if (key_ready) m_phase <= 2;
        2: if (m_round == final_of(m_dec, m_mode)) m_phase <= 3;
           else m_round <= m_round + 1;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("in_ready",   int'(in_ready),   int'(m_phase == 0));
      checkOutput("busy",       int'(busy),       int'(m_phase != 0));
      checkOutput("state_en",   int'(state_en),   int'(m_phase == 2));
      checkOutput("state_ld",   int'(state_ld),
                  int'(m_phase == 2 && m_round == first_of(m_dec, m_mode)));
      checkOutput("last_round", int'(last_round),
                  int'(m_phase == 2 && m_round == final_of(m_dec, m_mode)));
      checkOutput("out_valid",  int'(out_valid),  int'(m_phase == 3));
      checkOutput("round",      int'(round),      m_round);
      checkOutput("mode",       int'(mode),       int'(m_mode));
      checkOutput("dec",        int'(dec),        int'(m_dec));
    end
  end

  // One operation started in the current IDLE cycle; records what the DUT did
  // and compares against hand-computed first/final rounds and latency.
  task automatic run_op(input string name, input logic d, input logic [1:0] m,
                        input int key_delay, input int hold,
                        input int exp_first, input int exp_final,
                        input int exp_pulses, input int exp_latency);
    int   c = 1;
    int   n_en = 0, first_r = -1, last_r = -1, lat = -1, done_cycles = 0;
    bit   got = 0;
    logic outr, key;
    applyStimulus(1'b1, d, m, key_delay == 0, 1'b1);
    while (c < 200) begin
      if (state_en) begin
        if (n_en == 0) first_r = int'(round);
        n_en++;
      end
      if (last_round) last_r = int'(round);
      if (out_valid) begin
        if (!got) lat = c;
        got = 1;
        done_cycles++;
      end
      if (in_ready && got) break;
      outr = out_valid ? (done_cycles > hold) : 1'b1;
      key  = state_en ? logic'(c % 2) : logic'(c > key_delay);
      applyStimulus(out_valid && !outr, ~d, ~m, key, outr);
      c++;
    end
    checkOutput({name, "_timeout"}, int'(c >= 200), 0);
    checkOutput({name, "_first"},   first_r, exp_first);
    checkOutput({name, "_final"},   last_r,  exp_final);
    checkOutput({name, "_pulses"},  n_en,    exp_pulses);
    checkOutput({name, "_latency"}, lat,     exp_latency);
    checkOutput({name, "_done"},    done_cycles, hold + 1);
    checkOutput({name, "_mode"},    int'(mode),  int'(m));
    checkOutput({name, "_dec"},     int'(dec),   int'(d));
    checkOutput({name, "_round"},   int'(round), exp_final);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b1; dec_in = 1'b0; mode_in = 2'h0;
    key_ready = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("rst_in_ready",  int'(in_ready),  1);
    checkOutput("rst_busy",      int'(busy),      0);
    checkOutput("rst_round",     int'(round),     0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    applyStimulus(1'b0, 1'b0, 2'h0, 1'b1, 1'b1);
    checkOutput("rst_no_op", int'(in_ready), 1);

    run_op("aes128_enc", 1'b0, 2'h0, 0, 0,  0, 10, 11, 13);
    run_op("aes192_dec", 1'b1, 2'h2, 0, 0, 13, 25, 13, 15);
    run_op("aes256_dec", 1'b1, 2'h3, 3, 4, 15, 29, 15, 20);
    run_op("mode1_enc",  1'b0, 2'h1, 0, 0,  0, 10, 11, 13);

    applyStimulus(1'b1, 1'b1, 2'h1, 1'b1, 1'b1);
    n = 0;
    while (!(state_en && round == 5'd15) && n < 50) begin
      applyStimulus(1'b0, 1'b0, 2'h0, 1'b1, 1'b1);
      n++;
    end
    checkOutput("midrst_reach", int'(n < 50), 1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'h1, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("midrst_in_ready",   int'(in_ready),   1);
    checkOutput("midrst_busy",       int'(busy),       0);
    checkOutput("midrst_round",      int'(round),      0);
    checkOutput("midrst_mode",       int'(mode),       0);
    checkOutput("midrst_dec",        int'(dec),        0);
    checkOutput("midrst_state_en",   int'(state_en),   0);
    checkOutput("midrst_last_round", int'(last_round), 0);
    checkOutput("midrst_out_valid",  int'(out_valid),  0);

    run_op("after_rst", 1'b0, 2'h3, 0, 0, 0, 14, 15, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
